// File: rtl/mem_port_arbiter_if.sv
// CPU-side request/response buses and the main-memory port of the arbiter,
// bundled so the arbiter and its environment share one connection.
interface mem_port_arbiter_if;
  // Instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  // Load/store requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  // Main memory port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_owner;
  // Pipeline hold
  logic        cpu_stall;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata, mem_owner, cpu_stall
  );

  // CPU core + memory view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata, mem_owner, cpu_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported main memory between instruction fetch and load/store.
// Each access runs IDLE -> ISSUE -> (WAIT) -> (CAPT) -> RESP, or IDLE -> ERR
// for a misaligned address. Data wins ties unless fetch has waited through
// STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic SYS_clk,
  input  logic SYS_reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [2:0] WAIT_INIT  = 3'(READ_LATENCY - 1);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [3:0]  starve_reg, starve_next;
  logic        mem_en_reg, mem_en_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        owner_reg, owner_next;
  logic        if_ready_reg, if_ready_next;
  logic        d_ready_reg, d_ready_next;
  logic        if_err_reg, if_err_next;
  logic        d_err_reg, d_err_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;

  logic        fetch_win;
  logic [31:0] sel_addr;

  // Next-state, next-output and arbitration decision
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    starve_next    = starve_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    owner_next     = owner_reg;
    if_ready_next  = 1'b0;
    d_ready_next   = 1'b0;
    if_err_next    = 1'b0;
    d_err_next     = 1'b0;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;

    // Fetch takes the port when alone, or when data has starved it long enough
    fetch_win = bus.if_req && (!bus.d_req || (starve_reg >= STARVE_LIM));
    sel_addr  = fetch_win ? bus.if_addr : bus.d_addr;

    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          owner_next    = !fetch_win;
          mem_addr_next = sel_addr;
          mem_we_next   = !fetch_win && bus.d_we;
          if (!fetch_win) begin
            mem_wdata_next = bus.d_wdata;
          end
          if (fetch_win || !bus.if_req) begin
            starve_next = 4'd0;
          end else if (starve_reg != 4'hF) begin
            starve_next = starve_reg + 4'd1;
          end
          if (sel_addr[1:0] != 2'b00) begin
            // Misaligned: answer immediately with ready+err, memory untouched
            state_next    = ERR;
            if_ready_next = fetch_win;
            if_err_next   = fetch_win;
            d_ready_next  = !fetch_win;
            d_err_next    = !fetch_win;
          end else begin
            state_next  = ISSUE;
            mem_en_next = 1'b1;
          end
        end else begin
          starve_next = 4'd0;
        end
      end
      ISSUE: begin
        if (mem_we_reg) begin
          state_next    = RESP;
          if_ready_next = !owner_reg;
          d_ready_next  = owner_reg;
        end else if (READ_LATENCY == 1) begin
          state_next = CAPT;
        end else begin
          state_next = WAIT;
          cnt_next   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt_reg <= 3'd1) begin
          state_next = CAPT;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      CAPT: begin
        state_next    = RESP;
        if_ready_next = !owner_reg;
        d_ready_next  = owner_reg;
        if (owner_reg) begin
          d_rdata_next = bus.mem_rdata;
        end else begin
          if_rdata_next = bus.mem_rdata;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      starve_reg    <= 4'd0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      owner_reg     <= 1'b0;
      if_ready_reg  <= 1'b0;
      d_ready_reg   <= 1'b0;
      if_err_reg    <= 1'b0;
      d_err_reg     <= 1'b0;
      if_rdata_reg  <= 32'd0;
      d_rdata_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      starve_reg    <= starve_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      owner_reg     <= owner_next;
      if_ready_reg  <= if_ready_next;
      d_ready_reg   <= d_ready_next;
      if_err_reg    <= if_err_next;
      d_err_reg     <= d_err_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_owner = owner_reg;
  assign bus.if_ready  = if_ready_reg;
  assign bus.d_ready   = d_ready_reg;
  assign bus.if_err    = if_err_reg;
  assign bus.d_err     = d_err_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.cpu_stall = (bus.if_req & ~if_ready_reg) | (bus.d_req & ~d_ready_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a READ_LATENCY=1 instance driven by a vector
// table plus a contention sequence with a scoreboard, and a READ_LATENCY=4
// instance for long-latency and mid-access reset sequences.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic SYS_reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter_if b4();

  mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(3)) u_dut (
    .SYS_clk(clk), .SYS_reset(SYS_reset), .bus(bus));
  mem_port_arbiter #(.READ_LATENCY(4), .STARVE_LIMIT(3)) u_dut4 (
    .SYS_clk(clk), .SYS_reset(SYS_reset), .bus(b4));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h40) return 32'h0051_3023;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // Memory models: read data is valid only in the cycle READ_LATENCY after mem_en
  logic pend1, pend4;
  int age1, age4;
  logic [31:0] paddr1, paddr4;
  always @(posedge clk) begin
    if (SYS_reset) pend1 <= 1'b0;
    else if (bus.mem_en && !bus.mem_we) begin pend1 <= 1'b1; age1 <= 1; paddr1 <= bus.mem_addr; end
    else if (pend1) begin age1 <= age1 + 1; if (age1 == 1) pend1 <= 1'b0; end
  end
  always @(posedge clk) begin
    if (SYS_reset) pend4 <= 1'b0;
    else if (b4.mem_en && !b4.mem_we) begin pend4 <= 1'b1; age4 <= 1; paddr4 <= b4.mem_addr; end
    else if (pend4) begin age4 <= age4 + 1; if (age4 == 4) pend4 <= 1'b0; end
  end
  assign bus.mem_rdata = (pend1 && age1 == 1) ? data_of(paddr1) : 32'hBAD0_BAD0;
  assign b4.mem_rdata  = (pend4 && age4 == 4) ? data_of(paddr4) : 32'hBAD0_BAD0;

  // Scoreboard
  typedef struct packed { logic owner; logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct packed { logic owner; logic err; logic [31:0] rdata; } rsp_exp_t;
  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  mem_exp_t mem_r;
  rsp_exp_t rsp_r;
  logic [31:0] hold_if = 32'd0, hold_d = 32'd0;

  task automatic expect_txn(input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic err);
    logic [31:0] rd;
    if (!err) mem_q.push_back('{owner: is_d, we: is_d & we, addr: addr, wdata: wdata});
    if (err || (is_d && we)) rd = is_d ? hold_d : hold_if;
    else begin
      rd = data_of(addr);
      if (is_d) hold_d = rd; else hold_if = rd;
    end
    rsp_q.push_back('{owner: is_d, err: err, rdata: rd});
  endtask

  int cyc = 0;
  int last_en = -100;
  int min_gap = 1000;
  bit stray = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-port monitor
  always @(negedge clk) begin
    if (!SYS_reset && bus.mem_en) begin
      if (cyc - last_en < min_gap) min_gap = cyc - last_en;
      last_en = cyc;
      if (mem_q.size() == 0) check("mem_en_unexpected", 32'd1, 32'd0);
      else begin
        mem_r = mem_q.pop_front();
        check("mem_owner", {31'd0, bus.mem_owner}, {31'd0, mem_r.owner});
        check("mem_we", {31'd0, bus.mem_we}, {31'd0, mem_r.we});
        check("mem_addr", bus.mem_addr, mem_r.addr);
        if (mem_r.we) check("mem_wdata", bus.mem_wdata, mem_r.wdata);
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (!SYS_reset) begin
      if ((bus.if_err && !bus.if_ready) || (bus.d_err && !bus.d_ready) || (bus.if_ready && bus.d_ready))
        stray = 1'b1;
      if (bus.if_ready || bus.d_ready) begin
        if (rsp_q.size() == 0) check("ready_unexpected", 32'd1, 32'd0);
        else begin
          rsp_r = rsp_q.pop_front();
          check("rsp_port_is_data", {31'd0, bus.d_ready}, {31'd0, rsp_r.owner});
          check("rsp_mem_owner", {31'd0, bus.mem_owner}, {31'd0, rsp_r.owner});
          if (rsp_r.owner) begin
            check("d_err", {31'd0, bus.d_err}, {31'd0, rsp_r.err});
            check("d_rdata", bus.d_rdata, rsp_r.rdata);
          end else begin
            check("if_err", {31'd0, bus.if_err}, {31'd0, rsp_r.err});
            check("if_rdata", bus.if_rdata, rsp_r.rdata);
          end
        end
      end
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic        exp_err;
  } vec_t;
  vec_t vecs[9];

  task automatic wait_ready(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (is_d ? bus.d_ready : bus.if_ready) begin ok = 1'b1; return; end
    end
  endtask

  // Single transaction on the latency-1 instance; called just after a rising edge
  task automatic run_txn(input int idx, input vec_t v);
    int lat;
    bit stall_ok, done;
    expect_txn(v.is_d, v.we, v.addr, v.wdata, v.exp_err);
    if (v.is_d) begin bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata; end
    else begin bus.if_req = 1'b1; bus.if_addr = v.addr; end
    lat = 0; stall_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (v.is_d ? bus.d_ready : bus.if_ready) begin
        done = 1'b1;
        if (bus.cpu_stall) stall_ok = 1'b0;
      end else begin
        lat++;
        if (!bus.cpu_stall) stall_ok = 1'b0;
      end
    end
    $display("txn %0d: %s we=%0b addr=%h latency=%0d", idx, v.is_d ? "data " : "fetch", v.we, v.addr, lat);
    check("ready_seen", {31'd0, done}, 32'd1);
    check("latency", lat, v.exp_lat);
    check("cpu_stall_shape", {31'd0, stall_ok}, 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_en, c_rdy, n;
    bit ok;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    b4.if_req = 0;  b4.if_addr = 0;  b4.d_req = 0;  b4.d_we = 0;  b4.d_addr = 0;  b4.d_wdata = 0;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         3, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         3, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 2, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0042, 32'h0,         1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         3, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         3, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0201, 32'h1111_2222, 1, 1'b1};

    repeat (3) @(posedge clk);
    #1 SYS_reset = 1'b0;
    @(negedge clk);
    check("reset_state", {31'd0, |{bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ready,
          bus.d_ready, bus.if_rdata, bus.d_rdata, bus.if_err, bus.d_err, bus.mem_owner, bus.cpu_stall}}, 32'd0);

    // Long-latency load on the READ_LATENCY=4 instance
    @(posedge clk); #1;
    b4.d_req = 1'b1; b4.d_we = 1'b0; b4.d_addr = 32'h104;
    c_en = -1; c_rdy = -1;
    for (int c = 0; c < 20 && c_rdy < 0; c++) begin
      @(negedge clk);
      if (b4.mem_en && c_en < 0) c_en = c;
      if (b4.d_ready) c_rdy = c;
    end
    $display("txn rl4: data load addr=%h mem_en_cycle=%0d ready_cycle=%0d", 32'h104, c_en, c_rdy);
    check("rl4_mem_en_cycle", c_en, 1);
    check("rl4_ready_cycle", c_rdy, 6);
    check("rl4_d_rdata", b4.d_rdata, data_of(32'h104));
    @(posedge clk); #1 b4.d_req = 1'b0;

    // Reset while the access sits in WAIT; request held across reset
    @(posedge clk); #1;
    b4.d_req = 1'b1; b4.d_addr = 32'h108;
    repeat (3) @(negedge clk);
    SYS_reset = 1'b1;
    @(posedge clk); #1 SYS_reset = 1'b0;
    @(negedge clk);
    check("rl4_reset_outputs", {31'd0, |{b4.mem_en, b4.mem_we, b4.mem_addr, b4.mem_wdata, b4.if_ready,
          b4.d_ready, b4.if_rdata, b4.d_rdata, b4.if_err, b4.d_err, b4.mem_owner}}, 32'd0);
    @(negedge clk);
    check("rl4_restart_mem_en", {31'd0, b4.mem_en}, 32'd1);
    n = 0; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      n++;
      if (b4.d_ready) ok = 1'b1;
    end
    $display("txn rl4: restarted load addr=%h ready after %0d more cycles", 32'h108, n);
    check("rl4_restart_ready_delay", n, 5);
    check("rl4_restart_rdata", b4.d_rdata, data_of(32'h108));
    @(posedge clk); #1 b4.d_req = 1'b0;

    // Table-driven single transactions
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

    // Both requesters held continuously: grants D,D,D,F,D,D,D,F
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      int dk, fk;
      dk = (k < 3) ? k : (k < 7 ? k - 1 : 0);
      fk = (k == 3) ? 0 : 1;
      if (k == 3 || k == 7) expect_txn(1'b0, 1'b0, 32'h300 + 32'(4 * fk), 32'h0, 1'b0);
      else expect_txn(1'b1, 1'b0, 32'h200 + 32'(4 * dk), 32'h0, 1'b0);
    end
    fork
      begin
        bit okd;
        for (int k = 0; k < 6; k++) begin
          bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200 + 32'(4 * k);
          wait_ready(1'b1, okd);
          $display("txn contend: data load addr=%h done=%0b", bus.d_addr, okd);
          check("contend_d_ready", {31'd0, okd}, 32'd1);
          @(posedge clk); #1;
        end
        bus.d_req = 1'b0;
      end
      begin
        bit okf;
        for (int k = 0; k < 2; k++) begin
          bus.if_req = 1'b1; bus.if_addr = 32'h300 + 32'(4 * k);
          wait_ready(1'b0, okf);
          $display("txn contend: fetch addr=%h done=%0b", bus.if_addr, okf);
          check("contend_if_ready", {31'd0, okf}, 32'd1);
          @(posedge clk); #1;
        end
        bus.if_req = 1'b0;
      end
    join
    repeat (4) @(posedge clk);

    check("scoreboard_mem_drained", mem_q.size(), 0);
    check("scoreboard_rsp_drained", rsp_q.size(), 0);
    check("min_mem_en_gap_ge3", {31'd0, min_gap >= 3}, 32'd1);
    check("no_stray_err_or_dual_ready", {31'd0, stray}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
